// File: rtl/beam_trigger_pkg.sv
// Shared types and helpers for the beam trigger holdoff scaler.
// Count word, holdoff FSM state and saturating increment.
package beam_trigger_pkg;

  localparam int unsigned CNT_W = 32;
  localparam int unsigned SAT_W = 64;

  typedef logic [CNT_W-1:0] count_t;

  typedef enum logic {
    IDLE,
    HOLD
  } hold_state_e;

  // Add inc to v, clamping at 2^w-1 (w <= SAT_W).
  function automatic logic [SAT_W-1:0] sat_inc(
    input logic [SAT_W-1:0] v,
    input logic             inc,
    input int unsigned      w
  );
    logic [SAT_W-1:0] maxv;
    if (w >= SAT_W) maxv = '1;
    else maxv = (SAT_W'(1) << w) - SAT_W'(1);
    if (inc && (v < maxv)) return v + SAT_W'(1);
    return v;
  endfunction

endpackage

// File: rtl/beam_holdoff.sv
// Per-beam holdoff FSM: accepts a trigger, then ignores the
// beam for HOLDOFF_CLOCKS cycles. Emits a registered pulse.
module beam_holdoff
  import beam_trigger_pkg::*;
#(
  parameter int unsigned HOLDOFF_CLOCKS = 16
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic en_i,
  input  logic trig_i,
  output logic trig_o,
  output logic accept_o
);

  localparam int unsigned HW =
    (HOLDOFF_CLOCKS > 0) ? $clog2(HOLDOFF_CLOCKS + 1) : 1;

  hold_state_e   state_q, state_d;
  logic [HW-1:0] cnt_q, cnt_d;
  logic          trig_q;

  // State, holdoff counter and output pulse registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      trig_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      trig_q  <= accept_o;
    end
  end

  // Next state: load on accept, count down, release at 1.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!en_i) begin
      state_d = IDLE;
      cnt_d   = '0;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (accept_o && (HOLDOFF_CLOCKS > 0)) begin
            state_d = HOLD;
            cnt_d   = HW'(HOLDOFF_CLOCKS);
          end
        end
        HOLD: begin
          cnt_d = cnt_q - HW'(1);
          if (cnt_q == HW'(1)) state_d = IDLE;
        end
      endcase
    end
  end

  // Accept strobe: enabled, idle and trigger present.
  always_comb begin
    accept_o = en_i && (state_q == IDLE) && trig_i;
  end

  assign trig_o = trig_q;

endmodule

// File: rtl/beam_trigger_holdoff_scaler.sv
// Holdoff, per-period trigger counting and snapshot handshake.
// Optional raw_count_o via BEAM_TRIGGER_RAW_COUNT_EN.
module beam_trigger_holdoff_scaler
  import beam_trigger_pkg::*;
#(
  parameter int unsigned NBEAMS         = 2,
  parameter int unsigned HOLDOFF_CLOCKS = 16,
  parameter int unsigned PERIOD_CLOCKS  = 375000000,
  parameter int unsigned COUNT_BITS     = CNT_W
) (
  input  logic                                 aclk,
  input  logic                                 aresetn,
  input  logic                                 enable_i,
  input  logic [NBEAMS-1:0]                    trig_i,
  output logic [NBEAMS-1:0]                    trig_o,
  output logic [NBEAMS-1:0][COUNT_BITS-1:0]    count_o,
  output logic                                 count_valid_o,
  input  logic                                 count_ack_i,
  output logic                                 overrun_o
`ifdef BEAM_TRIGGER_RAW_COUNT_EN
  ,
  output logic [NBEAMS-1:0][COUNT_BITS-1:0]    raw_count_o
`endif
);

  localparam int unsigned PW = $clog2(PERIOD_CLOCKS);

  logic [PW-1:0]     per_q, per_d;
  logic              valid_q, valid_d;
  logic              ovr_q, ovr_d;
  logic              term;
  logic [NBEAMS-1:0] acc;

  assign term = enable_i && (per_q == PW'(PERIOD_CLOCKS - 1));

  // Period counter, snapshot valid and overrun next state.
  always_comb begin
    per_d   = '0;
    valid_d = valid_q;
    ovr_d   = 1'b0;
    if (enable_i && !term) per_d = per_q + PW'(1);
    if (term) begin
      valid_d = 1'b1;
      ovr_d   = valid_q && !count_ack_i;
    end else if (count_ack_i) begin
      valid_d = 1'b0;
    end
  end

  // Period counter and handshake registers.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      per_q   <= '0;
      valid_q <= 1'b0;
      ovr_q   <= 1'b0;
    end else begin
      per_q   <= per_d;
      valid_q <= valid_d;
      ovr_q   <= ovr_d;
    end
  end

  assign count_valid_o = valid_q;
  assign overrun_o     = ovr_q;

  for (genvar b = 0; b < NBEAMS; b++) begin : g_beam
    logic [COUNT_BITS-1:0] run_q, run_inc, snap_q;

    beam_holdoff #(
      .HOLDOFF_CLOCKS(HOLDOFF_CLOCKS)
    ) u_hold (
      .clk_i   (aclk),
      .rst_ni  (aresetn),
      .en_i    (enable_i),
      .trig_i  (trig_i[b]),
      .trig_o  (trig_o[b]),
      .accept_o(acc[b])
    );

    assign run_inc = COUNT_BITS'(
      sat_inc(SAT_W'(run_q), acc[b], COUNT_BITS));

    // Running count; terminal cycle folds it into the snapshot.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        run_q  <= '0;
        snap_q <= '0;
      end else begin
        if (!enable_i || term) run_q <= '0;
        else run_q <= run_inc;
        if (term) snap_q <= run_inc;
      end
    end

    assign count_o[b] = snap_q;

`ifdef BEAM_TRIGGER_RAW_COUNT_EN
    logic [COUNT_BITS-1:0] raw_q, raw_inc, raw_snap_q;

    assign raw_inc = COUNT_BITS'(
      sat_inc(SAT_W'(raw_q), enable_i && trig_i[b], COUNT_BITS));

    // Raw count of every high trigger cycle, same snapshot timing.
    always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
        raw_q      <= '0;
        raw_snap_q <= '0;
      end else begin
        if (!enable_i || term) raw_q <= '0;
        else raw_q <= raw_inc;
        if (term) raw_snap_q <= raw_inc;
      end
    end

    assign raw_count_o[b] = raw_snap_q;
`endif
  end

endmodule

// File: tb/tb_beam_trigger_holdoff_scaler.sv
// Scoreboard bench: two DUT builds (holdoff 16 / 32-bit counts and
// holdoff 0 / 3-bit counts) against a timestamp-based reference model.
module tb_beam_trigger_holdoff_scaler;

  localparam int P = 100;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic en = 1'b0;
  logic [1:0] trig = '0;
  logic ack = 1'b0;

  logic [1:0]       trig_a;
  logic [1:0][31:0] cnt_a;
  logic             valid_a, ovr_a;
  logic [1:0]       trig_b;
  logic [1:0][2:0]  cnt_b;
  logic             valid_b, ovr_b;

  always #5 clk = ~clk;

  beam_trigger_holdoff_scaler #(
    .NBEAMS(2), .HOLDOFF_CLOCKS(16),
    .PERIOD_CLOCKS(P), .COUNT_BITS(32)
  ) dut_a (
    .aclk(clk), .aresetn(rst_n), .enable_i(en),
    .trig_i(trig), .trig_o(trig_a), .count_o(cnt_a),
    .count_valid_o(valid_a), .count_ack_i(ack),
    .overrun_o(ovr_a)
  );

  beam_trigger_holdoff_scaler #(
    .NBEAMS(2), .HOLDOFF_CLOCKS(0),
    .PERIOD_CLOCKS(P), .COUNT_BITS(3)
  ) dut_b (
    .aclk(clk), .aresetn(rst_n), .enable_i(en),
    .trig_i(trig), .trig_o(trig_b), .count_o(cnt_b),
    .count_valid_o(valid_b), .count_ack_i(ack),
    .overrun_o(ovr_b)
  );

  typedef struct {
    logic [1:0] trig;
    logic       valid;
    logic       ovr;
    longint     c0;
    longint     c1;
  } out_t;

  typedef struct {
    out_t a;
    out_t b;
  } exp_t;

  exp_t q[$];
  int total = 0;
  int bad = 0;

  // reference model state, per DUT k
  int     hold[2] = '{16, 0};
  longint mx[2] = '{64'hFFFF_FFFF, 64'd7};
  int     t = 0;
  int     m_p[2];
  int     m_last[2][2];
  longint m_cnt[2][2];
  longint m_snap[2][2];
  bit     m_valid[2];

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_p[k] = 0;
      m_valid[k] = 0;
      for (int b = 0; b < 2; b++) begin
        m_last[k][b] = -1;
        m_cnt[k][b] = 0;
        m_snap[k][b] = 0;
      end
    end
  endfunction

  function automatic out_t step(int k, logic e, logic [1:0] tr,
                                logic a);
    out_t o;
    o.trig = '0;
    o.ovr = 0;
    if (!e) begin
      m_p[k] = 0;
      for (int b = 0; b < 2; b++) begin
        m_last[k][b] = -1;
        m_cnt[k][b] = 0;
      end
      if (a) m_valid[k] = 0;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (tr[b] && (m_last[k][b] < 0 ||
                      t - m_last[k][b] > hold[k])) begin
          o.trig[b] = 1'b1;
          m_last[k][b] = t;
          m_cnt[k][b]++;
        end
      end
      if (m_p[k] == P - 1) begin
        for (int b = 0; b < 2; b++) begin
          m_snap[k][b] = (m_cnt[k][b] > mx[k]) ? mx[k] : m_cnt[k][b];
          m_cnt[k][b] = 0;
        end
        o.ovr = m_valid[k] && !a;
        m_valid[k] = 1;
        m_p[k] = 0;
      end else begin
        if (a) m_valid[k] = 0;
        m_p[k]++;
      end
    end
    o.valid = m_valid[k];
    o.c0 = m_snap[k][0];
    o.c1 = m_snap[k][1];
    return o;
  endfunction

  task automatic chk(string nm, longint act, longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s t=%0t got=%0h want=%0h", nm, $time, act, exp);
    end
  endtask

  // drive one cycle of inputs and queue the expected outputs
  task automatic drive(logic e, logic [1:0] tr, logic a);
    exp_t x;
    en = e;
    trig = tr;
    ack = a;
    x.a = step(0, e, tr, a);
    x.b = step(1, e, tr, a);
    q.push_back(x);
    t++;
    @(negedge clk);
  endtask

  task automatic rand_cycles(int n);
    for (int i = 0; i < n; i++) begin
      logic e;
      logic [1:0] tr;
      e = ($urandom_range(0, 199) != 0);
      tr[0] = ($urandom_range(0, 3) == 0);
      tr[1] = ($urandom_range(0, 3) == 0);
      drive(e, tr, $urandom_range(0, 7) == 0);
    end
  endtask

  // monitor: compare DUT outputs to queued expectations
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("a_trig", longint'(trig_a), longint'(e.a.trig));
        chk("a_valid", longint'(valid_a), longint'(e.a.valid));
        chk("a_ovr", longint'(ovr_a), longint'(e.a.ovr));
        chk("a_cnt0", longint'(cnt_a[0]), e.a.c0);
        chk("a_cnt1", longint'(cnt_a[1]), e.a.c1);
        chk("b_trig", longint'(trig_b), longint'(e.b.trig));
        chk("b_valid", longint'(valid_b), longint'(e.b.valid));
        chk("b_ovr", longint'(ovr_b), longint'(e.b.ovr));
        chk("b_cnt0", longint'(cnt_b[0]), e.b.c0);
        chk("b_cnt1", longint'(cnt_b[1]), e.b.c1);
      end
    end
  end

  task automatic chk_reset(string nm);
    chk({nm, "_trig"}, longint'({trig_a, trig_b}), 0);
    chk({nm, "_cnt"}, longint'(cnt_a) | longint'(cnt_b), 0);
    chk({nm, "_valid"}, longint'({valid_a, valid_b}), 0);
    chk({nm, "_ovr"}, longint'({ovr_a, ovr_b}), 0);
  endtask

  initial begin
    model_reset();
    repeat (3) @(negedge clk);
    chk_reset("rst0");
    rst_n = 1'b1;
    drive(0, 2'b00, 0);
    drive(0, 2'b00, 0);
    // beam 0 held high for a whole period
    for (int i = 0; i < P; i++) drive(1, 2'b01, 0);
    // beam 1 pulse on terminal cycle, no ack -> overrun
    for (int i = 0; i < P; i++)
      drive(1, (m_p[0] == P - 1) ? 2'b10 : 2'b00, 0);
    // ack on the terminal cycle only
    for (int i = 0; i < P; i++) begin
      logic [1:0] tr;
      tr[0] = ($urandom_range(0, 5) == 0);
      tr[1] = ($urandom_range(0, 5) == 0);
      drive(1, tr, m_p[0] == P - 1);
    end
    rand_cycles(800);
    // restart period, fill a snapshot, then reset mid-holdoff
    drive(0, 2'b00, 1);
    for (int i = 0; i < P + 5; i++) drive(1, 2'b01, 0);
    rst_n = 1'b0;
    #1;
    chk_reset("rst1");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    drive(1, 2'b11, 0);
    for (int i = 0; i < 20; i++) drive(1, 2'b01, 0);
    rand_cycles(300);
    drive(0, 2'b00, 0);
    @(posedge clk);
    #3;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
